zigzag_reorder_pp: RTL and testbench
====================================

Name: zigzag_reorder_pp

Overview:
- Parametrised ping-pong coefficient reorder buffer for the FDCT→quantiser path of the JPEG encoder.
- Accepts an NxN block of coefficients in raster order, one per cycle, with a valid/ready handshake.
- Emits each block in zigzag order, or in raster order when mode=0.
- Two banks: one block is written while the previous one is read, so sustained throughput is 1 coefficient/cycle.

Parameters:
- DW, 12, coefficient width in bits.
- N, 8, block dimension; block holds N*N entries. Legal values: 2, 4, 8, 16.
- AW, 2*log2(N), entry address width (derived; do not override).

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  asynchronous, active-low reset.
- ena  in  1  clock enable; 0 freezes all state.
- mode  in  1  1 = zigzag output order, 0 = raster pass-through; sampled per block.
- in_valid  in  1  input coefficient valid.
- in_ready  out  1  buffer can accept a coefficient.
- in_data  in  DW  raster-order coefficient.
- out_valid  out  1  output register holds a valid coefficient.
- out_ready  in  1  consumer accepts the coefficient.
- out_data  out  DW  reordered coefficient.
- out_last  out  1  marks entry N*N-1 of a block on the output.
- bank_full  out  2  per-bank full flags (status).

Behaviour:
- Reset (rst=0, async): wr_bank=0, rd_bank=0, bank_full=0, wr_cnt=0, read walker at (0,0) with direction up; out_valid=0, out_last=0, out_data=0; in_ready=0 while in reset. Memory contents are not reset.
- Input accept: in_ready = ena & !bank_full[wr_bank]. A write occurs when in_valid & in_ready; it stores in_data at mem[wr_bank][wr_cnt] and increments wr_cnt.
- Write wrap: on the write with wr_cnt = N*N-1, wr_cnt returns to 0, bank_full[wr_bank] is set, and wr_bank toggles, all on the same edge.
- Read fetch condition: ena & bank_full[rd_bank] & (!out_valid | out_ready).
- On a fetch: out_data <= mem[rd_bank][addr]; out_valid <= 1; out_last <= (read index = N*N-1).
- No fetch but ena & out_valid & out_ready: out_valid <= 0, out_last <= 0.
- Mode latch: mode is captured on the fetch of index 0 and held for the remainder of the block.
- Raster mode (latched 0): addr = read index.
- Zigzag mode (latched 1): addr = r*N+c, driven by a walker state machine with states UP and DOWN, start (0,0) in UP.
- UP transitions, in priority order:
  - c=N-1: r+1, go to DOWN.
  - r=0: c+1, go to DOWN.
  - otherwise: r-1, c+1.
- DOWN transitions, in priority order:
  - r=N-1: c+1, go to UP.
  - c=0: r+1, go to UP.
  - otherwise: r+1, c-1.
- End of read block: on the fetch of index N*N-1, bank_full[rd_bank] clears, rd_bank toggles, and the walker returns to (0,0)/UP.
- Latency: if the last input write lands at edge k, the first out_valid is visible after edge k+1.
  - With out_ready held at 1, the block streams back-to-back with no gaps.
  - Consecutive blocks stream with no bubble.
- Simultaneous events:
  - A set and a clear of bank_full can occur on the same edge; they always target different banks.
  - A write into a bank and a read from the same bank cannot coincide, because writes require !full.
- Both banks full: in_ready=0 until the read side clears a bank. The input is never dropped or overwritten.
- ena=0: no write, no fetch, no state change. out_valid/out_data hold. A transfer counts only when ena=1.
- Reset mid-block: all partial write and read progress is discarded. After release the buffer is empty and out_valid=0.

Test Plan:
- N=8, mode=1, in_data = raster index 0..63, out_ready=1 → output 0,1,8,16,9,2,3,10,17,24,32,25,…,55,62,63. out_last only on 63. First out_valid at k+1.
- N=8, mode=0, same stimulus → output 0..63 in order. Flip mode mid-block → that block keeps its latched order.
- out_ready=0, stream 3 blocks → in_ready drops after 128 accepts and bank_full=2'b11. Raise out_ready → block 0 drains in zigzag order, then in_ready returns.
- N=4 instance, mode=1, input 0..15 → 0,1,4,8,5,2,3,6,9,12,13,10,7,11,14,15.
- Random in_valid/out_ready toggling over 10 blocks → scoreboard exact order, no loss or duplication. ena pulsed low for 5 cycles → all outputs and counters frozen.
- rst asserted after 30 inputs and mid-output → all outputs 0 immediately. After release, a fresh block produces the correct full sequence.

Source files
------------

// File: rtl/zigzag_reorder_pp.sv
// Ping-pong NxN coefficient buffer: raster-order writes, zigzag (mode=1) or raster (mode=0) reads.
// Latency: first coefficient of a block is registered on the edge after its last write.
// Backpressure: in_ready drops while the write bank is full; output holds while out_valid & !out_ready.
//
// Ports:
//   clk, rst (async active-low), ena (global clock enable, 0 freezes all state)
//   mode      : 1 = zigzag, 0 = raster; latched when index 0 of a block is fetched
//   in_valid / in_ready / in_data    : raster-order coefficient input
//   out_valid / out_ready / out_data : reordered coefficient output, out_last marks entry N*N-1
//   bank_full : per-bank full status
module zigzag_reorder_pp #(
  parameter int DW = 12,
  parameter int N  = 8,
  parameter int AW = 2 * $clog2(N)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          ena,
  input  logic          mode,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [DW-1:0] in_data,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [DW-1:0] out_data,
  output logic          out_last,
  output logic [1:0]    bank_full
);

  localparam int              LW       = $clog2(N);
  localparam int              DEPTH    = N * N;
  localparam logic [AW-1:0]   LAST_IDX = AW'(DEPTH - 1);
  localparam logic [LW-1:0]   MAX_RC   = LW'(N - 1);

  typedef enum logic {UP = 1'b0, DOWN = 1'b1} dir_e;

  logic [DW-1:0] mem [2][DEPTH];

  logic          wr_bank_q, wr_bank_d;
  logic          rd_bank_q, rd_bank_d;
  logic [1:0]    full_q, full_d;
  logic [AW-1:0] wr_cnt_q, wr_cnt_d;
  logic [AW-1:0] rd_idx_q, rd_idx_d;
  logic [LW-1:0] row_q, row_d;
  logic [LW-1:0] col_q, col_d;
  dir_e          dir_q, dir_d;
  logic          mode_q, mode_d;
  logic          out_valid_q, out_valid_d;
  logic          out_last_q, out_last_d;
  logic [DW-1:0] out_data_q, out_data_d;

  logic          wr_en;
  logic          fetch;
  logic          rd_last;
  logic          zz_mode;
  logic [AW-1:0] rd_addr;

  // in_ready is forced low while reset is asserted, not just after the registers clear.
  assign in_ready = rst & ena & ~full_q[wr_bank_q];
  assign wr_en    = in_valid & in_ready;
  assign fetch    = ena & full_q[rd_bank_q] & (~out_valid_q | out_ready);
  assign rd_last  = (rd_idx_q == LAST_IDX);

  // At index 0 the live mode input applies; it is latched for the rest of the block.
  assign zz_mode  = (rd_idx_q == '0) ? mode : mode_q;
  // N is a power of two, so r*N+c is a plain concatenation.
  assign rd_addr  = zz_mode ? {row_q, col_q} : rd_idx_q;

  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign out_last  = out_last_q;
  assign bank_full = full_q;

  always_comb begin
    wr_bank_d   = wr_bank_q;
    rd_bank_d   = rd_bank_q;
    full_d      = full_q;
    wr_cnt_d    = wr_cnt_q;
    rd_idx_d    = rd_idx_q;
    row_d       = row_q;
    col_d       = col_q;
    dir_d       = dir_q;
    mode_d      = mode_q;
    out_valid_d = out_valid_q;
    out_last_d  = out_last_q;
    out_data_d  = out_data_q;

    if (wr_en) begin
      if (wr_cnt_q == LAST_IDX) begin
        wr_cnt_d          = '0;
        full_d[wr_bank_q] = 1'b1;
        wr_bank_d         = ~wr_bank_q;
      end else begin
        wr_cnt_d = wr_cnt_q + AW'(1);
      end
    end

    if (fetch) begin
      out_data_d  = mem[rd_bank_q][rd_addr];
      out_valid_d = 1'b1;
      out_last_d  = rd_last;
      if (rd_idx_q == '0) mode_d = mode;

      if (rd_last) begin
        // Set (write side) and clear here never hit the same bank: a full
        // read bank blocks writes into it.
        full_d[rd_bank_q] = 1'b0;
        rd_bank_d         = ~rd_bank_q;
        rd_idx_d          = '0;
        row_d             = '0;
        col_d             = '0;
        dir_d             = UP;
      end else begin
        rd_idx_d = rd_idx_q + AW'(1);
        // Walker advances every fetch; it is only consulted in zigzag mode.
        unique case (dir_q)
          UP: begin
            if (col_q == MAX_RC) begin
              row_d = row_q + LW'(1);
              dir_d = DOWN;
            end else if (row_q == '0) begin
              col_d = col_q + LW'(1);
              dir_d = DOWN;
            end else begin
              row_d = row_q - LW'(1);
              col_d = col_q + LW'(1);
            end
          end
          DOWN: begin
            if (row_q == MAX_RC) begin
              col_d = col_q + LW'(1);
              dir_d = UP;
            end else if (col_q == '0) begin
              row_d = row_q + LW'(1);
              dir_d = UP;
            end else begin
              row_d = row_q + LW'(1);
              col_d = col_q - LW'(1);
            end
          end
          default: dir_d = UP;
        endcase
      end
    end else if (ena & out_valid_q & out_ready) begin
      out_valid_d = 1'b0;
      out_last_d  = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_bank_q   <= 1'b0;
      rd_bank_q   <= 1'b0;
      full_q      <= 2'b00;
      wr_cnt_q    <= '0;
      rd_idx_q    <= '0;
      row_q       <= '0;
      col_q       <= '0;
      dir_q       <= UP;
      mode_q      <= 1'b0;
      out_valid_q <= 1'b0;
      out_last_q  <= 1'b0;
      out_data_q  <= '0;
    end else begin
      wr_bank_q   <= wr_bank_d;
      rd_bank_q   <= rd_bank_d;
      full_q      <= full_d;
      wr_cnt_q    <= wr_cnt_d;
      rd_idx_q    <= rd_idx_d;
      row_q       <= row_d;
      col_q       <= col_d;
      dir_q       <= dir_d;
      mode_q      <= mode_d;
      out_valid_q <= out_valid_d;
      out_last_q  <= out_last_d;
      out_data_q  <= out_data_d;
    end
  end

  // Coefficient storage is not reset.
  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_bank_q][wr_cnt_q] <= in_data;
  end

endmodule

// File: tb/tb_zigzag_reorder_pp.sv
module tb_zigzag_reorder_pp;
  localparam int DW = 12;
  localparam int N  = 8;
  localparam int NN = N * N;

  logic          clk = 1'b0;
  logic          rst, ena, mode;
  logic          in_valid, in_ready;
  logic [DW-1:0] in_data;
  logic          out_valid, out_ready, out_last;
  logic [DW-1:0] out_data;
  logic [1:0]    bank_full;

  logic          in_valid4, in_ready4, out_valid4, out_ready4, out_last4;
  logic [DW-1:0] out_data4;
  logic [1:0]    bank_full4;

  int checks = 0;
  int errors = 0;

  logic [DW-1:0] blk_q[$];
  logic [DW-1:0] exp_d[$];
  bit            exp_l[$];
  logic [DW-1:0] got_d[$];
  bit            got_l[$];
  logic [DW-1:0] got4[$];

  always #5 clk = ~clk;

  zigzag_reorder_pp #(.DW(DW), .N(N)) dut (
    .clk(clk), .rst(rst), .ena(ena), .mode(mode),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_last(out_last), .bank_full(bank_full)
  );

  zigzag_reorder_pp #(.DW(DW), .N(4)) dut4 (
    .clk(clk), .rst(rst), .ena(ena), .mode(mode),
    .in_valid(in_valid4), .in_ready(in_ready4), .in_data(in_data),
    .out_valid(out_valid4), .out_ready(out_ready4), .out_data(out_data4),
    .out_last(out_last4), .bank_full(bank_full4)
  );

  // k-th position of zigzag order as a raster index: walk anti-diagonals s=r+c,
  // even diagonals run bottom-left to top-right, odd ones top-right to bottom-left.
  function automatic int zz_raster(input int n, input int k);
    int cnt, lo, hi, r;
    cnt = 0;
    for (int s = 0; s <= 2 * n - 2; s++) begin
      lo = (s < n) ? 0 : s - n + 1;
      hi = (s < n) ? s : n - 1;
      for (int j = 0; j <= hi - lo; j++) begin
        r = (s % 2 == 0) ? hi - j : lo + j;
        if (cnt == k) return r * n + (s - r);
        cnt++;
      end
    end
    return -1;
  endfunction

  // Reference model: collects accepted inputs, emits a block's expected output
  // once all N*N entries have arrived. Also records every output transfer.
  always @(negedge clk) begin
    if (rst && ena) begin
      if (in_valid && in_ready) begin
        blk_q.push_back(in_data);
        if (blk_q.size() == NN) begin
          for (int k = 0; k < NN; k++) begin
            exp_d.push_back(mode ? blk_q[zz_raster(N, k)] : blk_q[k]);
            exp_l.push_back(k == NN - 1);
          end
          blk_q.delete();
        end
      end
      if (out_valid && out_ready) begin
        got_d.push_back(out_data);
        got_l.push_back(out_last);
      end
      if (out_valid4 && out_ready4) got4.push_back(out_data4);
    end
  end

  task automatic clear_sb();
    blk_q.delete(); exp_d.delete(); exp_l.delete();
    got_d.delete(); got_l.delete(); got4.delete();
  endtask

  // Drives consecutive values start, start+1, ... until count are accepted or budget expires.
  task automatic drive_seq(input int start, input int count, input int budget, output int acc);
    int cyc;
    bit take;
    acc = 0;
    cyc = 0;
    while (acc < count && cyc < budget) begin
      in_valid = 1'b1;
      in_data  = DW'(start + acc);
      @(negedge clk);
      take = in_ready;
      @(posedge clk); #1;
      if (take) acc++;
      cyc++;
    end
    in_valid = 1'b0;
  endtask

  task automatic wait_drain(input int n, input int budget, output bit ok);
    int cyc;
    cyc = 0;
    while (got_d.size() < n && cyc < budget) begin
      @(posedge clk); #1;
      cyc++;
    end
    ok = (got_d.size() >= n);
    repeat (3) @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b0; ena = 1'b1; mode = 1'b1;
    in_valid = 1'b0; in_data = '0; out_ready = 1'b1;
    in_valid4 = 1'b0; out_ready4 = 1'b1;
    #12;
    checks++;
    if (out_valid !== 1'b0 || out_last !== 1'b0 || out_data !== '0) begin
      errors++;
      $display("FAIL reset_outputs: got v=%b l=%b d=%0d want 0/0/0", out_valid, out_last, out_data);
    end
    checks++;
    if (bank_full !== 2'b00 || in_ready !== 1'b0) begin
      errors++;
      $display("FAIL reset_status: got full=%b in_ready=%b want 00/0", bank_full, in_ready);
    end
    @(negedge clk); rst = 1'b1;
    @(posedge clk); #1;
    checks++;
    if (in_ready !== 1'b1) begin
      errors++;
      $display("FAIL reset_release_ready: got %b want 1", in_ready);
    end
  endtask

  task automatic test_zigzag();
    int acc;
    bit ok;
    int head[12] = '{0, 1, 8, 16, 9, 2, 3, 10, 17, 24, 32, 25};
    clear_sb();
    mode = 1'b1; out_ready = 1'b1;
    drive_seq(0, NN, 200, acc);
    checks++;
    if (out_valid !== 1'b0) begin
      errors++;
      $display("FAIL zz_latency_k: out_valid got %b want 0 right after last write", out_valid);
    end
    @(posedge clk); #1;
    checks++;
    if (out_valid !== 1'b1 || out_data !== '0) begin
      errors++;
      $display("FAIL zz_latency_k1: got v=%b d=%0d want v=1 d=0", out_valid, out_data);
    end
    repeat (NN - 1) @(posedge clk);
    @(negedge clk); #1;
    checks++;
    if (got_d.size() != NN) begin
      errors++;
      $display("FAIL zz_gapless: got %0d outputs after %0d cycles want %0d", got_d.size(), NN, NN);
    end
    wait_drain(NN, 200, ok);
    checks++;
    if (!ok || exp_d.size() != NN) begin
      errors++;
      $display("FAIL zz_count: got %0d outputs, model %0d, want %0d", got_d.size(), exp_d.size(), NN);
    end
    for (int i = 0; i < 12 && i < got_d.size(); i++) begin
      checks++;
      if (got_d[i] !== DW'(head[i])) begin
        errors++;
        $display("FAIL zz_table[%0d]: got %0d want %0d", i, got_d[i], head[i]);
      end
    end
    for (int i = 0; i < NN && i < got_d.size() && i < exp_d.size(); i++) begin
      checks++;
      if (got_d[i] !== exp_d[i] || got_l[i] !== exp_l[i]) begin
        errors++;
        $display("FAIL zz_order[%0d]: got %0d/last=%b want %0d/last=%b", i, got_d[i], got_l[i], exp_d[i], exp_l[i]);
      end
    end
  endtask

  task automatic test_raster_flip();
    int acc, cyc;
    bit ok;
    clear_sb();
    mode = 1'b0; out_ready = 1'b1;
    drive_seq(100, NN, 200, acc);
    cyc = 0;
    while (got_d.size() < 10 && cyc < 100) begin
      @(posedge clk); #1;
      cyc++;
    end
    mode = 1'b1;
    wait_drain(NN, 200, ok);
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL raster_count: got %0d outputs want %0d", got_d.size(), NN);
    end
    for (int i = 0; i < NN && i < got_d.size(); i++) begin
      checks++;
      if (got_d[i] !== DW'(100 + i) || got_l[i] !== (i == NN - 1)) begin
        errors++;
        $display("FAIL raster_order[%0d]: got %0d/last=%b want %0d/last=%b", i, got_d[i], got_l[i], 100 + i, i == NN - 1);
      end
    end
  endtask

  task automatic test_backpressure();
    int acc, acc2, cyc;
    bit ok;
    clear_sb();
    mode = 1'b1; out_ready = 1'b0;
    drive_seq(0, 3 * NN, 200, acc);
    checks++;
    if (acc != 2 * NN || in_ready !== 1'b0 || bank_full !== 2'b11) begin
      errors++;
      $display("FAIL bp_stall: got accepts=%0d in_ready=%b full=%b want %0d/0/11", acc, in_ready, bank_full, 2 * NN);
    end
    checks++;
    if (out_valid !== 1'b1 || out_data !== '0) begin
      errors++;
      $display("FAIL bp_hold: got v=%b d=%0d want v=1 d=0", out_valid, out_data);
    end
    out_ready = 1'b1;
    cyc = 0;
    while (in_ready !== 1'b1 && cyc < 200) begin
      @(posedge clk); #1;
      cyc++;
    end
    checks++;
    if (in_ready !== 1'b1 || got_d.size() != NN - 1) begin
      errors++;
      $display("FAIL bp_release: got in_ready=%b after %0d outputs want 1 after %0d", in_ready, got_d.size(), NN - 1);
    end
    drive_seq(acc, NN, 200, acc2);
    wait_drain(3 * NN, 500, ok);
    checks++;
    if (!ok || exp_d.size() != 3 * NN) begin
      errors++;
      $display("FAIL bp_count: got %0d outputs, model %0d, want %0d", got_d.size(), exp_d.size(), 3 * NN);
    end
    for (int i = 0; i < got_d.size() && i < exp_d.size(); i++) begin
      checks++;
      if (got_d[i] !== exp_d[i] || got_l[i] !== exp_l[i]) begin
        errors++;
        $display("FAIL bp_order[%0d]: got %0d/last=%b want %0d/last=%b", i, got_d[i], got_l[i], exp_d[i], exp_l[i]);
      end
    end
  endtask

  task automatic test_n4();
    int cyc, acc;
    bit take;
    int tbl[16] = '{0, 1, 4, 8, 5, 2, 3, 6, 9, 12, 13, 10, 7, 11, 14, 15};
    clear_sb();
    mode = 1'b1;
    acc = 0; cyc = 0;
    while (acc < 16 && cyc < 100) begin
      in_valid4 = 1'b1;
      in_data   = DW'(acc);
      @(negedge clk);
      take = in_ready4;
      @(posedge clk); #1;
      if (take) acc++;
      cyc++;
    end
    in_valid4 = 1'b0;
    cyc = 0;
    while (got4.size() < 16 && cyc < 100) begin
      @(posedge clk); #1;
      cyc++;
    end
    checks++;
    if (got4.size() != 16) begin
      errors++;
      $display("FAIL n4_count: got %0d want 16", got4.size());
    end
    for (int i = 0; i < got4.size() && i < 16; i++) begin
      checks++;
      if (got4[i] !== DW'(tbl[i]) || tbl[i] != zz_raster(4, i)) begin
        errors++;
        $display("FAIL n4_order[%0d]: got %0d want %0d", i, got4[i], tbl[i]);
      end
    end
  endtask

  task automatic test_random();
    int acc_a, cyc_a, cyc_b;
    bit take;
    logic          s_v, s_l;
    logic [DW-1:0] s_d;
    logic [1:0]    s_f;
    clear_sb();
    mode = 1'b1;
    fork
      begin
        acc_a = 0; cyc_a = 0;
        while (acc_a < 10 * NN && cyc_a < 20000) begin
          in_valid = ($urandom_range(0, 3) != 0);
          in_data  = DW'($urandom);
          @(negedge clk);
          take = in_valid && in_ready;
          @(posedge clk); #1;
          if (take) acc_a++;
          cyc_a++;
        end
        in_valid = 1'b0;
      end
      begin
        cyc_b = 0;
        while (got_d.size() < 10 * NN && cyc_b < 20000) begin
          out_ready = ($urandom_range(0, 2) != 0);
          if (cyc_b == 150) begin
            ena = 1'b0;
            s_v = out_valid; s_d = out_data; s_l = out_last; s_f = bank_full;
            for (int j = 0; j < 5; j++) begin
              @(posedge clk); #1;
              checks++;
              if (out_valid !== s_v || out_data !== s_d || out_last !== s_l || bank_full !== s_f || in_ready !== 1'b0) begin
                errors++;
                $display("FAIL ena_freeze[%0d]: got v=%b d=%0d l=%b f=%b rdy=%b want v=%b d=%0d l=%b f=%b rdy=0",
                         j, out_valid, out_data, out_last, bank_full, in_ready, s_v, s_d, s_l, s_f);
              end
            end
            ena = 1'b1;
          end
          @(posedge clk); #1;
          cyc_b++;
        end
        out_ready = 1'b1;
      end
    join
    repeat (10) @(posedge clk);
    #1;
    checks++;
    if (got_d.size() != 10 * NN || exp_d.size() != 10 * NN) begin
      errors++;
      $display("FAIL rand_count: got %0d outputs, model %0d, want %0d", got_d.size(), exp_d.size(), 10 * NN);
    end
    for (int i = 0; i < got_d.size() && i < exp_d.size(); i++) begin
      checks++;
      if (got_d[i] !== exp_d[i] || got_l[i] !== exp_l[i]) begin
        errors++;
        $display("FAIL rand_order[%0d]: got %0d/last=%b want %0d/last=%b", i, got_d[i], got_l[i], exp_d[i], exp_l[i]);
      end
    end
  endtask

  task automatic test_reset_midblock();
    int acc;
    bit ok;
    clear_sb();
    mode = 1'b1; out_ready = 1'b1;
    drive_seq(0, NN + 30, 300, acc);
    rst = 1'b0;
    #1;
    checks++;
    if (out_valid !== 1'b0 || out_data !== '0 || out_last !== 1'b0 || bank_full !== 2'b00 || in_ready !== 1'b0) begin
      errors++;
      $display("FAIL rst_mid: got v=%b d=%0d l=%b f=%b rdy=%b want 0/0/0/00/0", out_valid, out_data, out_last, bank_full, in_ready);
    end
    clear_sb();
    repeat (2) @(posedge clk);
    #3;
    rst = 1'b1;
    @(posedge clk); #1;
    checks++;
    if (out_valid !== 1'b0 || bank_full !== 2'b00) begin
      errors++;
      $display("FAIL rst_empty: got v=%b f=%b want 0/00", out_valid, bank_full);
    end
    drive_seq(200, NN, 200, acc);
    wait_drain(NN, 200, ok);
    checks++;
    if (!ok || got_d.size() != NN || exp_d.size() != NN) begin
      errors++;
      $display("FAIL rst_fresh_count: got %0d outputs, model %0d, want %0d", got_d.size(), exp_d.size(), NN);
    end
    for (int i = 0; i < got_d.size() && i < exp_d.size(); i++) begin
      checks++;
      if (got_d[i] !== exp_d[i] || got_l[i] !== exp_l[i]) begin
        errors++;
        $display("FAIL rst_fresh_order[%0d]: got %0d/last=%b want %0d/last=%b", i, got_d[i], got_l[i], exp_d[i], exp_l[i]);
      end
    end
  endtask

  initial begin
    test_reset();
    test_zigzag();
    test_raster_flip();
    test_backpressure();
    test_n4();
    test_random();
    test_reset_midblock();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
